// File: rtl/fetch_stage.sv
// Instruction fetch stage: tags imem fetches, loads the IR with a valid bit, kills wrong-path words on flush.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter int             D          = 10,
  parameter int             W          = 9,
  parameter logic [W-1:0]   HALT_INSTR = 9'h1FF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] pc_in,
  input  logic [W-1:0] imem_data,
  input  logic         flush,
  output logic [W-1:0] ir,
  output logic [D-1:0] ir_pc,
  output logic         ir_valid,
  output logic [2:0]   opcode,
  output logic         busy,
  output logic         done,
  output logic [15:0]  perf_fetched,
  output logic [15:0]  perf_bubbles
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // What this edge does to the fetch pipeline, resolved in priority order.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_START,
    ACT_HALT,
    ACT_FLUSH,
    ACT_FETCH
  } act_t;

  state_t       state;
  state_t       state_next;
  act_t         act;
  logic         fv1;
  logic [D-1:0] fpc1;
  logic         halt_seen;

  assign halt_seen = ir_valid && (ir == HALT_INSTR);

  // ---------------------------------------------------------------------------
  // Run/halt FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a signal
    // unassigned and infers a latch.
    state_next = state;
    act        = ACT_HOLD;
    if (start) begin
      state_next = RUN;
      act        = ACT_START;
    end else if (state == RUN) begin
      if (halt_seen) begin
        state_next = DONE;
        act        = ACT_HALT;
      end else if (flush) begin
        act = ACT_FLUSH;
      end else begin
        act = ACT_FETCH;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch pipeline: fetch tag (fv1/fpc1) then instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fv1      <= 1'b0;
      fpc1     <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      if ((act == ACT_FETCH) || (act == ACT_FLUSH)) begin
        // On flush the data still moves but both stages are marked dead.
        fpc1     <= pc_in;
        ir       <= imem_data;
        ir_pc    <= fpc1;
        fv1      <= (act == ACT_FETCH);
        ir_valid <= (act == ACT_FETCH) && fv1;
      end else begin
        // Start, halt and the idle states all kill anything in flight.
        fv1      <= 1'b0;
        ir_valid <= 1'b0;
      end
    end
  end

  assign opcode = ir[W-1:W-3];
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef FETCH_PERF_EN
  logic [15:0] fetched_q;
  logic [15:0] bubbles_q;
  logic        fetched_inc;
  logic        bubble_inc;

  assign fetched_inc = (act == ACT_FETCH) && fv1;
  // Any non-start edge spent in RUN without a valid IR is a bubble.
  assign bubble_inc  = ((act == ACT_FETCH) || (act == ACT_FLUSH)) && !ir_valid;

  always_ff @(posedge clk) begin
    if (reset || (act == ACT_START)) begin
      fetched_q <= '0;
      bubbles_q <= '0;
    end else begin
      if (fetched_inc && (fetched_q != 16'hFFFF)) begin
        fetched_q <= fetched_q + 16'd1;
      end
      if (bubble_inc && (bubbles_q != 16'hFFFF)) begin
        bubbles_q <= bubbles_q + 16'd1;
      end
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_fetched = 16'h0000;
  assign perf_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table-driven straight-line/flush/halt run,
// plus hand-written restart, mid-run reset and halt-with-flush sequences.
module tb_fetch_stage;
  localparam int D = 10;
  localparam int W = 9;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         flush;
  logic [D-1:0] pc_in;
  logic [W-1:0] imem_data;
  logic [W-1:0] ir;
  logic [D-1:0] ir_pc;
  logic         ir_valid;
  logic [2:0]   opcode;
  logic         busy;
  logic         done;
  logic [15:0]  perf_fetched;
  logic [15:0]  perf_bubbles;

  always #5 clk = ~clk;

  // Synchronous instruction memory model: data for the address of the previous cycle.
  logic [W-1:0] mem [0:(1<<D)-1];
  always @(posedge clk) imem_data <= mem[pc_in];

  fetch_stage #(.D(D), .W(W), .HALT_INSTR(9'h1FF)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pc_in        (pc_in),
    .imem_data    (imem_data),
    .flush        (flush),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .opcode       (opcode),
    .busy         (busy),
    .done         (done),
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
  );

  typedef struct {
    logic         start;
    logic         flush;
    logic [D-1:0] pc;
    logic         exp_valid;
    logic [D-1:0] exp_ir_pc;
    logic [W-1:0] exp_ir;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  vec_t vecs [19];
  int   n_checks = 0;
  int   n_err    = 0;

  function automatic vec_t mk(input logic s, input logic f, input int pc, input logic v,
                              input int ipc, input int iw, input logic b, input logic dn);
    vec_t r;
    r.start     = s;
    r.flush     = f;
    r.pc        = D'(pc);
    r.exp_valid = v;
    r.exp_ir_pc = D'(ipc);
    r.exp_ir    = W'(iw);
    r.exp_busy  = b;
    r.exp_done  = dn;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic f, input int p);
    start = s;
    flush = f;
    pc_in = D'(p);
  endtask

  task automatic check_ir(input string tag, input logic v, input int ipc, input int iw);
    logic [W-1:0] w;
    w = W'(iw);
    check({tag, " ir_valid"}, 32'(ir_valid), 32'(v));
    if (v) begin
      check({tag, " ir_pc"},  32'(ir_pc),  32'(ipc));
      check({tag, " ir"},     32'(ir),     32'(w));
      check({tag, " opcode"}, 32'(opcode), 32'(w[W-1:W-3]));
    end
  endtask

  task automatic check_state(input string tag, input logic b, input logic dn);
    check({tag, " busy"}, 32'(busy), 32'(b));
    check({tag, " done"}, 32'(done), 32'(dn));
  endtask

  task automatic check_perf(input string tag, input int f, input int b);
    check({tag, " perf_fetched"}, 32'(perf_fetched), PERF ? 32'(f) : 32'd0);
    check({tag, " perf_bubbles"}, 32'(perf_bubbles), PERF ? 32'(b) : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << D); i++) mem[i] = W'(i + 5);
    mem[46] = 9'h1FF;

    // Run 1: start pulse, 0..3 straight-line, jump 3->40 (4 and 5 killed), halt at 46.
    vecs[0]  = mk(1, 0,  0, 0,  0,   0, 0, 0);
    vecs[1]  = mk(0, 0,  0, 0,  0,   0, 1, 0);
    vecs[2]  = mk(0, 0,  1, 0,  0,   0, 1, 0);
    vecs[3]  = mk(0, 0,  2, 1,  0,   5, 1, 0);
    vecs[4]  = mk(0, 0,  3, 1,  1,   6, 1, 0);
    vecs[5]  = mk(0, 0,  4, 1,  2,   7, 1, 0);
    vecs[6]  = mk(0, 1,  5, 1,  3,   8, 1, 0);
    vecs[7]  = mk(0, 0, 40, 0,  0,   0, 1, 0);
    vecs[8]  = mk(0, 0, 41, 0,  0,   0, 1, 0);
    vecs[9]  = mk(0, 0, 42, 1, 40,  45, 1, 0);
    vecs[10] = mk(0, 0, 43, 1, 41,  46, 1, 0);
    vecs[11] = mk(0, 0, 44, 1, 42,  47, 1, 0);
    vecs[12] = mk(0, 0, 45, 1, 43,  48, 1, 0);
    vecs[13] = mk(0, 0, 46, 1, 44,  49, 1, 0);
    vecs[14] = mk(0, 0, 47, 1, 45,  50, 1, 0);
    vecs[15] = mk(0, 0, 48, 1, 46, 511, 1, 0);
    vecs[16] = mk(0, 0, 49, 0,  0,   0, 0, 1);
    vecs[17] = mk(0, 1, 50, 0,  0,   0, 0, 1);
    vecs[18] = mk(0, 0, 51, 0,  0,   0, 0, 1);

    reset = 1'b1;
    drive(0, 0, 0);
    repeat (2) tick();
    check("reset ir", 32'(ir), 32'd0);
    check("reset ir_pc", 32'(ir_pc), 32'd0);
    check_ir("reset", 1'b0, 0, 0);
    check("reset opcode", 32'(opcode), 32'd0);
    check_state("reset", 1'b0, 1'b0);
    check_perf("reset", 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].start, vecs[i].flush, int'(vecs[i].pc));
      check_ir($sformatf("run1[%0d]", i), vecs[i].exp_valid, int'(vecs[i].exp_ir_pc),
               int'(vecs[i].exp_ir));
      check_state($sformatf("run1[%0d]", i), vecs[i].exp_busy, vecs[i].exp_done);
      tick();
    end
    check_perf("run1 end", 11, 4);

    // Run 2: restart from DONE, fetch to PC 19, then hold start 3 cycles mid-run.
    drive(1, 0, 0);
    check_state("run2 pre", 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, k);
      if (k >= 2) check_ir($sformatf("run2 k=%0d", k), 1'b1, k - 2, k + 3);
      else        check_ir($sformatf("run2 k=%0d", k), 1'b0, 0, 0);
      tick();
    end
    drive(1, 0, 0);
    check_ir("restart c0", 1'b1, 18, 23);
    check_perf("restart c0", 19, 2);
    tick();
    for (int c = 1; c < 3; c++) begin
      drive(1, 0, 0);
      check_ir($sformatf("restart c%0d", c), 1'b0, 0, 0);
      check_state($sformatf("restart c%0d", c), 1'b1, 1'b0);
      check_perf($sformatf("restart c%0d", c), 0, 0);
      tick();
    end
    drive(0, 0, 0);
    check_ir("restart s", 1'b0, 0, 0);
    tick();
    drive(0, 0, 1);
    check_ir("restart s+1", 1'b0, 0, 0);
    check_perf("restart s+1", 0, 1);
    tick();
    drive(0, 0, 2);
    check_ir("restart s+2", 1'b1, 0, 5);
    check_perf("restart s+2", 1, 2);
    tick();
    drive(0, 0, 3);
    check_ir("restart s+3", 1'b1, 1, 6);
    tick();

    // Mid-run reset with start and flush also asserted.
    reset = 1'b1;
    drive(1, 1, 4);
    tick();
    reset = 1'b0;
    drive(0, 0, 5);
    check("midreset ir", 32'(ir), 32'd0);
    check("midreset ir_pc", 32'(ir_pc), 32'd0);
    check_ir("midreset", 1'b0, 0, 0);
    check_state("midreset", 1'b0, 1'b0);
    check_perf("midreset", 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(0, 0, 6 + c);
      check_ir($sformatf("idle c%0d", c), 1'b0, 0, 0);
      check_state($sformatf("idle c%0d", c), 1'b0, 1'b0);
    end
    tick();

    // Run 3: halt word at address 6, flush asserted on the halt edge.
    mem[6] = 9'h1FF;
    drive(1, 0, 0);
    tick();
    for (int k = 0; k <= 8; k++) begin
      drive(0, (k == 8), k);
      if (k >= 2) check_ir($sformatf("run3 k=%0d", k), 1'b1, k - 2, (k == 8) ? 511 : k + 3);
      else        check_ir($sformatf("run3 k=%0d", k), 1'b0, 0, 0);
      check_state($sformatf("run3 k=%0d", k), 1'b1, 1'b0);
      tick();
    end
    for (int k = 9; k < 12; k++) begin
      drive(0, (k == 10), k);
      check_ir($sformatf("halted k=%0d", k), 1'b0, 0, 0);
      check_state($sformatf("halted k=%0d", k), 1'b0, 1'b1);
      tick();
    end
    check_perf("run3 end", 7, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage sitting directly downstream of the program counter. It tags each PC value driven to the synchronous instruction memory, captures the returned word into an instruction register (IR) with a valid bit, and kills wrong-path words when a taken jump or branch flushes the pipe. It tracks run/halt state so that decode sees only valid instructions between `start` and a HALT word.

## Interface
- `D`, 10: PC / instruction-address width.
- `W`, 9: instruction width.
- `HALT_INSTR`, 9'h1FF: encoding that ends the program.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  program start/restart; the PC clears to 0 on the same edge.
- `pc_in`  in  D  current PC, also driven to the imem address.
- `imem_data`  in  W  imem read data for the address presented one cycle earlier.
- `flush`  in  1  a taken jump or branch updates the PC at this edge.
- `ir`  out  W  instruction register.
- `ir_pc`  out  D  address the IR word was fetched from.
- `ir_valid`  out  1  IR holds a right-path instruction.
- `opcode`  out  3  `ir[W-1:W-3]`, combinational from `ir`; drives the PC's instruction input.
- `busy`  out  1  state == RUN.
- `done`  out  1  state == DONE.
- `perf_fetched`  out  16  count of valid instructions delivered.
- `perf_bubbles`  out  16  count of RUN cycles with `ir_valid`=0.

## Operation
- Internal registers: `fv1` / `fpc1` hold the valid bit and address of the fetch issued last cycle. `state` is one of IDLE, RUN, DONE.
- Reset:
  - state = IDLE.
  - `ir`, `ir_pc`, `fv1`, `fpc1`, `ir_valid`, perf counters = 0.
  - `busy` = 0, `done` = 0.
- Priority per edge: reset > start > halt > flush > normal.
- On a `start` edge, from any state:
  - state → RUN.
  - `fv1` and `ir_valid` → 0.
  - Perf counters clear.
  - While `start` is held, these clears repeat (the PC is held at 0).
- RUN, normal edge:
  - `fpc1` ← `pc_in`; `fv1` ← 1.
  - `ir` ← `imem_data`; `ir_pc` ← `fpc1`; `ir_valid` ← `fv1`.
- RUN with `flush`=1:
  - `fv1` ← 0 and `ir_valid` ← 0. This kills both the word returning now and the fetch issued now.
  - `ir` and `ir_pc` still load but are don't-care.
- Halt: in RUN, `ir_valid`=1 and `ir`==HALT_INSTR.
  - At that edge: state → DONE, `fv1` and `ir_valid` → 0.
  - `flush` on the same edge is ignored.
- IDLE and DONE:
  - `fv1` and `ir_valid` are forced to 0.
  - `flush` is ignored.
  - Only `start` leaves these states.
- `pc_in` wrap from 2^D−1 to 0 needs no special handling.
- Perf counters saturate at 16'hFFFF.

## Timing
- Fetch latency: `pc_in`=A in cycle t → `ir`=mem[A], `ir_pc`=A, `ir_valid`=1 in cycle t+2.
- After `start` drops at cycle s, the first valid IR (address 0) appears at s+2. `ir_valid` is 0 during s and s+1.
- Taken-jump penalty: with `flush` in cycle f, `ir_valid`=0 in f+1 and f+2, and the target instruction is valid in f+3.
- Throughput: one instruction per cycle absent flushes.
- HALT word valid in cycle h → `done`=1 and `busy`=0 from h+1.
- `opcode` has zero latency from `ir`.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetched` increments on every edge that loads `ir_valid`=1.
  - `perf_bubbles` increments on every RUN-state edge where current `ir_valid`=0.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Straight-line fetch: reset, pulse `start` 1 cycle, imem[i]=i+5 → IR sequence 5,6,7… with `ir_pc` 0,1,2…; first valid 2 cycles after `start` falls.
- Jump flush: `flush` in cycle with `ir_pc`=3, PC → 40 → `ir_valid`=0 for 2 cycles, then `ir_pc`=40; addresses 4 and 5 never valid.
- Halt: imem[6]=9'h1FF → that word valid once, `done`=1 next cycle, `ir_valid` stays 0; flush asserted simultaneously is ignored.
- Restart mid-run: `start` held 3 cycles at PC≈20 → `ir_valid`=0 throughout, restart at `ir_pc`=0; counters cleared (FETCH_PERF_EN).
- Reset mid-run: `reset` asserted with `start`=1 and `flush`=1 → state IDLE, all outputs 0, no valid until next `start`.
- Perf (FETCH_PERF_EN): 10 sequential + 1 flush + halt → `perf_fetched`=11 (including the HALT word), `perf_bubbles`=4 (2 after start, 2 after flush).
